// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx - 16x oversampling UART receiver (start bit, DBIT data bits sent
// LSB first, stop bit of SB_TICK ticks).
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         synchronous active-low reset (0 = reset)
//   rx            asynchronous serial line, idle high
//   s_tick        oversampling strobe, one clk wide, 16 per bit period
//   rx_done_tick  one-clk pulse when a frame completes
//   dout          last received byte, held until the next completion
//   frame_err     stop bit was sampled low on the last completed frame
//   busy          receiver is somewhere inside a frame (FSM not IDLE)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err,
    output logic            busy
);

    // Tick counter must reach SB_TICK-1 in the stop bit and 15 in data bits.
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);           // middle of start bit
    localparam logic [SW-1:0] S_BIT  = SW'(15);          // one full bit period
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1); // end of stop sampling
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            done_next;

    logic            rx_meta;
    logic            rx_s;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous serial line.
    // NOTE: both flops reset to 1 (the idle line level) so that leaving reset
    // can never look like a falling start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // -----------------------------------------------------------------------
    // State and datapath registers, plus the registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of everything it reads.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            frame_err    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            rx_done_tick <= done_next;
            // dout/frame_err change on the same edge that raises rx_done_tick
            if (done_next) begin
                dout      <= b_reg;
                frame_err <= ~rx_s;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Counters move only on s_tick, except the clear when
    // a start edge is first seen in IDLE.
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can infer a latch.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx - self-checking bench for uart_rx.
//
// The bench keeps a frame-level model: every frame it puts on the line that
// must be received pushes {expected frame_err, expected byte} onto a queue.
// A compare process pops one entry per rx_done_tick pulse and checks every
// cycle that dout/frame_err equal the last popped values, that the pulse is
// one clk wide, and that reset clears the outputs. Directed checks with
// literal values pin the model after each scenario.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_PER_BIT = 64;  // 16 ticks x 4 clk per tick

    logic       clk;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;
    int pulses   = 0;

    logic [8:0] exp_q[$];   // {frame_err, byte}
    logic [7:0] m_dout;
    logic       m_ferr;
    logic       prev_done;

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick: one clk high out of every four, free running (also in reset).
    initial begin
        s_tick = 1'b0;
        forever begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                s_tick = (k == 3);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Compare process: samples 1 time unit after each rising edge.
    // -----------------------------------------------------------------------
    always @(posedge clk) begin : compare
        logic rst_now;
        logic [8:0] e;
        rst_now = reset;
        #1;
        if (!rst_now) begin
            m_dout    = 8'h00;
            m_ferr    = 1'b0;
            prev_done = 1'b0;
            check("reset_done", rx_done_tick, 0);
            check("reset_busy", busy, 0);
        end else begin
            check("done_one_clk", {31'd0, prev_done & rx_done_tick}, 0);
            if (rx_done_tick === 1'b1) begin
                pulses++;
                check("pulse_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e      = exp_q.pop_front();
                    m_dout = e[7:0];
                    m_ferr = e[8];
                end
            end
            prev_done = rx_done_tick;
        end
        check("model_dout", dout, m_dout);
        check("model_ferr", frame_err, m_ferr);
    end

    // Drive one frame: start bit, 8 data bits LSB first, stop bit of
    // stop_clk clocks at stop_lvl, then leave the line idle high.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                              input int stop_clk, input bit expect_out);
        if (expect_out) exp_q.push_back({~stop_lvl, d});
        rx = 1'b0;
        repeat (CLK_PER_BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CLK_PER_BIT) @(negedge clk);
            if (i == 1 && expect_out) check("busy_in_frame", busy, 1);
        end
        rx = stop_lvl;
        repeat (stop_clk) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin : stim
        int base;
        reset = 1'b0;
        rx    = 1'b1;

        // Reset with rx toggling and ticks running.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_dout", dout, 8'h00);
        check("post_reset_ferr", frame_err, 0);
        check("post_reset_done", rx_done_tick, 0);

        // Single byte.
        base = pulses;
        send_frame(8'hA5, 1'b1, CLK_PER_BIT, 1'b1);
        drain("a5_drain");
        check("a5_pulses", pulses - base, 1);
        check("a5_dout", dout, 8'hA5);
        check("a5_ferr", frame_err, 0);
        check("a5_busy_after", busy, 0);
        repeat (50) @(negedge clk);

        // Back-to-back, no idle gap.
        base = pulses;
        send_frame(8'h00, 1'b1, CLK_PER_BIT, 1'b1);
        send_frame(8'hFF, 1'b1, CLK_PER_BIT, 1'b1);
        send_frame(8'h3C, 1'b1, CLK_PER_BIT, 1'b1);
        drain("b2b_drain");
        check("b2b_pulses", pulses - base, 3);
        check("b2b_dout", dout, 8'h3C);
        check("b2b_ferr", frame_err, 0);
        repeat (50) @(negedge clk);

        // False start: low for 5 tick periods only.
        base = pulses;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_pulses", pulses - base, 0);
        check("glitch_dout", dout, 8'h3C);
        check("glitch_busy", busy, 0);

        // Framing error: stop bit low long enough to be sampled, then idle.
        // The still-low line re-enters START and is rejected as a glitch.
        base = pulses;
        send_frame(8'h55, 1'b0, 48, 1'b1);
        repeat (100) @(negedge clk);
        drain("ferr_drain");
        check("ferr_pulses", pulses - base, 1);
        check("ferr_dout", dout, 8'h55);
        check("ferr_flag", frame_err, 1);
        check("ferr_busy", busy, 0);
        send_frame(8'h12, 1'b1, CLK_PER_BIT, 1'b1);
        drain("good_drain");
        check("good_dout", dout, 8'h12);
        check("good_ferr", frame_err, 0);
        repeat (50) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xC3, then a clean 0x81.
        base = pulses;
        rx = 1'b0;
        repeat (CLK_PER_BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hC3 >> i) & 8'h01;
            repeat (CLK_PER_BIT) @(negedge clk);
        end
        rx = 1'b0;  // bit 4 of 0xC3
        repeat (32) @(negedge clk);
        check("midframe_busy", busy, 1);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_pulses", pulses - base, 0);
        check("abort_dout", dout, 8'h00);
        check("abort_busy", busy, 0);
        send_frame(8'h81, 1'b1, CLK_PER_BIT, 1'b1);
        drain("r81_drain");
        check("r81_pulses", pulses - base, 1);
        check("r81_dout", dout, 8'h81);
        check("r81_ferr", frame_err, 0);

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver that sits directly downstream of the baud-rate tick generator. It consumes its one-clock `max_tick` pulse as `s_tick`.
- Recovers 8N1-style frames from the serial line `rx` and presents each received byte on `dout`, with a one-cycle `rx_done_tick` strobe.
- Feeds the interface/ALU stage that captures the received bytes.

Parameters:
- DBIT, 8, number of data bits per frame, LSB first.
- SB_TICK, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- rx  input  1  asynchronous serial line; idle high.
- s_tick  input  1  oversampling strobe, one clk wide, 16 per bit period (from baud generator max_tick).
- rx_done_tick  output  1  one-clk pulse when a frame completes.
- dout  output  DBIT  last received data byte; held until next completion.
- frame_err  output  1  stop bit sampled low on the last completed frame; held until next completion.
- busy  output  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset: when reset==0 at a clk edge, all of the following are cleared:
  - state=IDLE, s=0, n=0, shift reg b=0.
  - dout=0, rx_done_tick=0, frame_err=0, busy=0.
  - both synchronizer flops=1 (line idle).
  - Reset overrides everything, including mid-frame and coincident s_tick; no partial byte is ever output.
- Input sync:
  - rx passes through 2 flops to give rx_s; this adds 2 clk of latency.
  - The FSM only looks at rx_s.
- Counters:
  - s is a 4-bit tick counter sized for 16 (5 bits when SB_TICK>16; width = clog2(SB_TICK)).
  - n counts bits, clog2(DBIT) wide.
  - Counters change only on s_tick cycles, apart from the IDLE->START clear.
- FSM states:
  - IDLE:
    - busy=0.
    - If rx_s==0 (independent of s_tick), go to START with s=0.
  - START:
    - On s_tick with s==7 (mid start bit):
      - if rx_s==0, go to DATA with s=0, n=0;
      - else it is a false start (glitch): return to IDLE with no output.
    - Other s_tick: s=s+1.
  - DATA:
    - On s_tick with s==15 (mid data bit):
      - s=0 and b={rx_s, b[DBIT-1:1]} (LSB first).
      - If n==DBIT-1, go to STOP; else n=n+1.
    - Other s_tick: s=s+1.
  - STOP:
    - On s_tick with s==SB_TICK-1:
      - go to IDLE;
      - dout<=b;
      - frame_err<=~rx_s;
      - rx_done_tick=1 for exactly the next clk cycle (registered).
    - Other s_tick: s=s+1.
- Completion rules:
  - rx_done_tick is never asserted for more than one clk.
  - dout and frame_err update in the same cycle rx_done_tick rises.
- Line held low at completion:
  - A frame with a low stop bit still completes and still pulses rx_done_tick, with frame_err=1.
  - On return to IDLE, a still-low rx_s immediately starts a new START.
  - A break condition therefore yields repeated frames of dout=0 with frame_err=1.
- Ticks: s_tick absent means the FSM holds state indefinitely; there is no timeout.
- Back-to-back frames: a new start edge is accepted on the first clk after returning to IDLE; no idle gap is required beyond the stop bit.

Test Plan:
- Reset: hold reset=0 for 5 clk with rx toggling and s_tick active -> dout=0x00, rx_done_tick=0, frame_err=0, busy=0; busy stays 0 after release while rx=1.
- Single byte: s_tick every 4 clk; drive frame 0xA5 (start 0, bits LSB first, stop 1) at 64 clk/bit -> exactly one rx_done_tick pulse, 1 clk wide; dout=0xA5, frame_err=0, busy low afterward.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap -> three pulses, dout sequence 0x00, 0xFF, 0x3C, all frame_err=0.
- False start: low glitch of 5 s_tick periods (shorter than 8) on idle line -> FSM returns to IDLE, no rx_done_tick, dout unchanged.
- Framing error: send 0x55 with stop bit 0 -> rx_done_tick pulses, dout=0x55, frame_err=1; next good frame 0x12 -> frame_err=0.
- Reset mid-frame: assert reset=0 during data bit 4 of 0xC3, release, then send 0x81 -> no output for the aborted frame; one pulse with dout=0x81.
